vga_text_pixel_serializer: RTL

Generates 640x480 VGA timing and turns an 80x30 text buffer into the per-pixel on/off stream that feeds the RGB colouring stage.
- Each pixel: reads the character code from an external synchronous character RAM, then the glyph row from an external synchronous 8x16 font ROM, and selects one bit.
- Outputs `serial_output` and `display_area`, plus `hsync`, `vsync` and a frame pulse, all aligned through one fixed-latency pipeline.
- Sits between the text/character store and the colour stage.

---
 rtl/vga_text_pixel_serializer_if.sv | 24 ++
 rtl/vga_text_pixel_serializer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/vga_text_pixel_serializer_if.sv
// Memory-side bus of the text pixel serializer: character RAM and font ROM
// read ports. Both memories are synchronous with a fixed 1-cycle read latency.
interface vga_text_pixel_serializer_if;
    logic [11:0] char_addr;
    logic [7:0]  char_code;
    logic [11:0] font_addr;
    logic [7:0]  font_data;

    // The serializer issues addresses and consumes data.
    modport master (
        output char_addr,
        output font_addr,
        input  char_code,
        input  font_data
    );

    // The memories accept addresses and return data.
    modport slave (
        input  char_addr,
        input  font_addr,
        output char_code,
        output font_data
    );
endinterface

// File: rtl/vga_text_pixel_serializer.sv
// VGA timing generator and text-mode pixel serializer. Counters drive a
// 5-stage pipeline: char address, char RAM read, font address, font ROM
// read, and bit select. Sync, blanking and frame-start markers travel
// down the same pipeline so every output lines up with serial_output.
module vga_text_pixel_serializer #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned COLS     = 80
) (
    input  logic vga_clk,
    input  logic reset,
    vga_text_pixel_serializer_if.master mem,
    output logic hsync,
    output logic vsync,
    output logic display_area,
    output logic serial_output,
    output logic frame_start
);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  h;
    logic [9:0]  v;
    logic        active;
    logic        hs_n;
    logic        vs_n;
    logic        first_pix;
    logic [5:0]  text_row;
    logic [6:0]  text_col;
    logic [11:0] row_base;
    logic [11:0] cell_addr;

    // Per-stage delay lines; index 0 is loaded at T+1.
    logic [3:0][2:0] hx_sr;
    logic [1:0][3:0] vl_sr;
    logic [3:0]      active_sr;
    logic [3:0]      hs_sr;
    logic [3:0]      vs_sr;
    logic [3:0]      fs_sr;

    // Raster counters: h wraps every line, v advances on each h wrap.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    // Raw timing decode and text cell address for the current counter cycle.
    always_comb begin
        active    = (h < H_ACT) && (v < V_ACT);
        hs_n      = !((h >= HS_BEG) && (h < HS_END));
        vs_n      = !((v >= VS_BEG) && (v < VS_END));
        first_pix = (h == 10'd0) && (v == 10'd0);
        text_row  = v[9:4];
        text_col  = h[9:3];
        cell_addr = row_base + {5'b0, text_col};
    end

    // 80 columns: row*80 as row*64 + row*16 keeps the adder tree small.
    if (COLS == 80) begin : g_cols80
        assign row_base = {text_row, 6'b0} + {2'b0, text_row, 4'b0};
    end else begin : g_cols_any
        assign row_base = 12'(text_row * 12'(COLS));
    end

    // Fetch pipeline and aligned output registers.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            mem.char_addr <= '0;
            mem.font_addr <= '0;
            hx_sr         <= '0;
            vl_sr         <= '0;
            active_sr     <= '0;
            hs_sr         <= '1;
            vs_sr         <= '1;
            fs_sr         <= '0;
            hsync         <= 1'b1;
            vsync         <= 1'b1;
            display_area  <= 1'b0;
            serial_output <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            mem.char_addr <= active ? cell_addr : 12'd0;
            // char_code now belongs to the pixel sitting in stage 1.
            mem.font_addr <= {mem.char_code, vl_sr[1]};
            hx_sr         <= {hx_sr[2:0], h[2:0]};
            vl_sr         <= {vl_sr[0], v[3:0]};
            active_sr     <= {active_sr[2:0], active};
            hs_sr         <= {hs_sr[2:0], hs_n};
            vs_sr         <= {vs_sr[2:0], vs_n};
            fs_sr         <= {fs_sr[2:0], first_pix};
            hsync         <= hs_sr[3];
            vsync         <= vs_sr[3];
            display_area  <= active_sr[3];
            // Bit 7 is the leftmost pixel, so 7-x == ~x for a 3-bit x.
            serial_output <= mem.font_data[~hx_sr[3]] & active_sr[3];
            frame_start   <= fs_sr[3];
        end
    end

endmodule
